// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared types and constants for the SDRAM port arbiter
package sdram_arb_pkg;
    typedef enum logic [1:0] {INIT, IDLE, SLOT} state_t;
    typedef enum logic {SLOT_ACCESS, SLOT_REFRESH} slot_t;
    localparam logic [1:0] PORT_VID = 2'd0;
    localparam logic [1:0] PORT_CPU = 2'd1;
    localparam logic [1:0] PORT_EXP = 2'd2;
    localparam int DEF_SLOT_LEN = 8;
    localparam int DEF_CS_HIGH = 2;
endpackage

// File: rtl/sdram_refresh_timer.sv
// sdram_refresh_timer: free-running interval timer that raises a sticky refresh request
module sdram_refresh_timer #(
    parameter int REFRESH_INTERVAL = 500
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic refresh_pending
);
    localparam int W = $clog2(REFRESH_INTERVAL);
    logic [W-1:0] cnt_q;
    logic         pend_q;
    logic         wrap;
    assign wrap = enable && cnt_q == W'(REFRESH_INTERVAL - 1);
    assign refresh_pending = pend_q;
    // count while enabled; a wrap sets pending and wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            if (enable) cnt_q <= wrap ? '0 : cnt_q + 1'b1;
            pend_q <= wrap || (pend_q && !clear);
        end
    end
endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: three-port arbiter and slot sequencer for the byte-wide SDRAM controller
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int SLOT_LEN         = DEF_SLOT_LEN,
    parameter int CS_HIGH          = DEF_CS_HIGH,
    parameter int REFRESH_INTERVAL = 500,
    parameter int INIT_CYCLES      = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [22:0] p0_addr,
    input  logic [7:0]  p0_din,
    output logic        p0_ack,
    output logic [7:0]  p0_dout,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [22:0] p1_addr,
    input  logic [7:0]  p1_din,
    output logic        p1_ack,
    output logic [7:0]  p1_dout,
    input  logic        p2_req,
    input  logic        p2_we,
    input  logic [22:0] p2_addr,
    input  logic [7:0]  p2_din,
    output logic        p2_ack,
    output logic [7:0]  p2_dout,
    output logic        mem_cs,
    output logic        mem_we,
    output logic [22:0] mem_addr,
    output logic [7:0]  mem_din,
    input  logic [7:0]  mem_dout,
    output logic        mem_refresh,
    output logic        init_done,
    output logic        busy
);
    localparam int SW = $clog2(SLOT_LEN);
    localparam int IW = $clog2(INIT_CYCLES + 1);
    localparam logic [SW:0] CS_END = (SW + 1)'(CS_HIGH);

    state_t          state_q;
    slot_t           slot_type_q;
    logic [1:0]      slot_port_q;
    logic [1:0]      ptr_q;
    logic [IW-1:0]   init_cnt_q;
    logic [SW-1:0]   slot_cnt_q;
    logic            init_done_q, busy_q, mem_cs_q, mem_ref_q, mem_we_q;
    logic [22:0]     mem_addr_q;
    logic [7:0]      mem_din_q;
    logic [2:0]      ack_q;
    logic [7:0]      dout_q [3];

    logic [2:0]      req, we, elig;
    logic [22:0]     addr [3];
    logic [7:0]      din [3];
    logic            refresh_pending, refresh_done, slot_last;
    logic [SW:0]     slot_nxt;
    logic            pick_valid_d, pick_ref_d;
    logic [1:0]      pick_port_d;

    assign req  = {p2_req, p1_req, p0_req};
    assign we   = {p2_we, p1_we, p0_we};
    assign addr = '{p0_addr, p1_addr, p2_addr};
    assign din  = '{p0_din, p1_din, p2_din};
    assign elig = req & ~ack_q;

    assign slot_last    = slot_cnt_q == SW'(SLOT_LEN - 1);
    assign slot_nxt     = {1'b0, slot_cnt_q} + 1'b1;
    assign refresh_done = state_q == SLOT && slot_last && slot_type_q == SLOT_REFRESH;

    assign {p2_ack, p1_ack, p0_ack} = ack_q;
    assign p0_dout     = dout_q[0];
    assign p1_dout     = dout_q[1];
    assign p2_dout     = dout_q[2];
    assign mem_cs      = mem_cs_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_din     = mem_din_q;
    assign mem_refresh = mem_ref_q;
    assign init_done   = init_done_q;
    assign busy        = busy_q;

    sdram_refresh_timer #(.REFRESH_INTERVAL(REFRESH_INTERVAL)) u_refresh (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable          (init_done_q),
        .clear           (refresh_done),
        .refresh_pending (refresh_pending)
    );

    // pick the next slot owner: refresh, then video, then CPU/expansion round-robin
    always_comb begin
        pick_valid_d = 1'b1;
        pick_ref_d   = 1'b0;
        pick_port_d  = PORT_VID;
        if (refresh_pending) pick_ref_d = 1'b1;
        else if (elig[PORT_VID]) pick_port_d = PORT_VID;
        else if (elig[PORT_CPU] && (ptr_q == PORT_CPU || !elig[PORT_EXP])) pick_port_d = PORT_CPU;
        else if (elig[PORT_EXP]) pick_port_d = PORT_EXP;
        else pick_valid_d = 1'b0;
    end

    // init window, grant latching and slot sequencing with registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= INIT;
            slot_type_q <= SLOT_ACCESS;
            slot_port_q <= PORT_VID;
            ptr_q       <= PORT_CPU;
            init_cnt_q  <= '0;
            slot_cnt_q  <= '0;
            init_done_q <= 1'b0;
            busy_q      <= 1'b0;
            mem_cs_q    <= 1'b0;
            mem_ref_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            ack_q       <= '0;
            for (int i = 0; i < 3; i++) dout_q[i] <= '0;
        end else begin
            ack_q <= '0;
            case (state_q)
                INIT: begin
                    init_cnt_q <= init_cnt_q + 1'b1;
                    if (init_cnt_q == IW'(INIT_CYCLES - 1)) begin
                        init_done_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                IDLE: begin
                    if (pick_valid_d) begin
                        state_q     <= SLOT;
                        slot_cnt_q  <= '0;
                        busy_q      <= 1'b1;
                        slot_port_q <= pick_port_d;
                        slot_type_q <= pick_ref_d ? SLOT_REFRESH : SLOT_ACCESS;
                        mem_ref_q   <= pick_ref_d;
                        mem_cs_q    <= !pick_ref_d;
                        if (!pick_ref_d) begin
                            mem_we_q   <= we[pick_port_d];
                            mem_addr_q <= addr[pick_port_d];
                            mem_din_q  <= din[pick_port_d];
                            if (pick_port_d != PORT_VID)
                                ptr_q <= pick_port_d == PORT_CPU ? PORT_EXP : PORT_CPU;
                        end
                    end
                end
                SLOT: begin
                    slot_cnt_q <= slot_cnt_q + 1'b1;
                    mem_cs_q   <= slot_type_q == SLOT_ACCESS && slot_nxt < CS_END;
                    mem_ref_q  <= slot_type_q == SLOT_REFRESH && slot_nxt < CS_END;
                    if (slot_last) begin
                        state_q  <= IDLE;
                        mem_we_q <= 1'b0;
                        busy_q   <= 1'b0;
                        if (slot_type_q == SLOT_ACCESS) begin
                            ack_q[slot_port_q] <= 1'b1;
                            if (!mem_we_q) dout_q[slot_port_q] <= mem_dout;
                        end
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed stimulus with an ack scoreboard for sdram_port_arbiter
module tb_sdram_port_arbiter;
    logic        clk, reset_n;
    logic        p0_req, p0_we, p0_ack, p1_req, p1_we, p1_ack, p2_req, p2_we, p2_ack;
    logic [22:0] p0_addr, p1_addr, p2_addr, mem_addr;
    logic [7:0]  p0_din, p1_din, p2_din, p0_dout, p1_dout, p2_dout, mem_din, mem_dout;
    logic        mem_cs, mem_we, mem_refresh, init_done, busy;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        int         port;
        int         cyc;
        bit         chk;
        logic [7:0] dout;
    } exp_t;
    exp_t exp_q[$];

    sdram_port_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_din(p0_din), .p0_ack(p0_ack), .p0_dout(p0_dout),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_din(p1_din), .p1_ack(p1_ack), .p1_dout(p1_dout),
        .p2_req(p2_req), .p2_we(p2_we), .p2_addr(p2_addr), .p2_din(p2_din), .p2_ack(p2_ack), .p2_dout(p2_dout),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_refresh(mem_refresh), .init_done(init_done), .busy(busy)
    );

    // controller model: read data is a fixed function of the latched address
    assign mem_dout = mem_addr[7:0] ^ 8'hE0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cycle index: number of clock edges since reset was released
    always @(posedge clk) cyc <= reset_n ? cyc + 1 : 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, req_v, cyc);
        end
    endtask

    task automatic push(input int port, input int c, input bit chk, input logic [7:0] d);
        exp_t e;
        e.port = port;
        e.cyc = c;
        e.chk = chk;
        e.dout = d;
        exp_q.push_back(e);
    endtask

    task automatic at(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] dout_of(input int p);
        return p == 0 ? p0_dout : p == 1 ? p1_dout : p2_dout;
    endfunction

    // monitor: every ack must match the head of the scoreboard in port, cycle and data
    always @(negedge clk) begin
        if ({p2_ack, p1_ack, p0_ack} != 3'b000) begin
            if (exp_q.size() == 0) check("unexpected_ack", {29'd0, p2_ack, p1_ack, p0_ack}, 0);
            else begin
                automatic exp_t e = exp_q.pop_front();
                check("ack_port", {29'd0, p2_ack, p1_ack, p0_ack}, 32'(3'b001 << e.port));
                check("ack_cyc", cyc, e.cyc);
                if (e.chk) check("ack_dout", {24'd0, dout_of(e.port)}, {24'd0, e.dout});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1);
    end

    initial begin
        automatic bit bad;
        reset_n = 1'b0;
        {p0_req, p0_we, p2_req, p2_we} = '0;
        {p0_addr, p2_addr, p0_din, p1_din, p2_din} = '0;
        p1_req = 1'b1;
        p1_we = 1'b0;
        p1_addr = 23'h012345;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", {mem_cs, mem_we, mem_refresh, busy, init_done, p0_ack, p1_ack, p2_ack}, 0);
        check("rst_data", {1'b0, mem_addr, mem_din}, 0);
        check("rst_dout", {p0_dout, p1_dout, p2_dout}, 0);
        // init window with a held read on port 1
        push(1, 265, 1, 8'hA5);
        reset_n = 1'b1;
        bad = 0;
        for (int i = 1; i < 256; i++) begin
            at(i);
            if (mem_cs || mem_refresh || busy || init_done) bad = 1;
        end
        check("init_quiet", bad, 0);
        at(256); check("init_done_rise", {init_done, mem_cs}, 2'b10);
        at(257); check("rd_start", {mem_cs, busy, mem_we}, 3'b110);
        check("rd_addr", mem_addr, 23'h012345);
        at(258); check("rd_cs_hold", mem_cs, 1);
        at(259); check("rd_cs_low", {mem_cs, busy}, 2'b01);
        at(265); p1_req = 1'b0;
        at(268); check("rd_dout_held", p1_dout, 8'hA5);
        // single write on port 2
        at(270);
        p2_req = 1'b1; p2_we = 1'b1; p2_addr = 23'h7FFFFF; p2_din = 8'h3C;
        push(2, 279, 1, 8'h00);
        bad = 0;
        for (int i = 271; i <= 278; i++) begin
            at(i);
            if (!(mem_we && busy && mem_din == 8'h3C && mem_addr == 23'h7FFFFF)) bad = 1;
        end
        check("wr_stable", bad, 0);
        at(279); check("wr_end", {mem_we, busy, mem_cs}, 0);
        p2_req = 1'b0; p2_we = 1'b0;
        at(280); check("wr_ack_pulse", {p2_ack, mem_we}, 0);
        // contention: everyone requests, video drops after its third grant
        at(290);
        p0_addr = 23'h000010; p1_addr = 23'h000021; p2_addr = 23'h000032;
        p0_req = 1'b1; p1_req = 1'b1; p2_req = 1'b1;
        push(0, 299, 1, 8'hF0); push(1, 308, 1, 8'hC1); push(0, 317, 1, 8'hF0);
        push(2, 326, 1, 8'hD2); push(0, 335, 1, 8'hF0); push(1, 344, 1, 8'hC1);
        push(2, 353, 1, 8'hD2); push(1, 362, 1, 8'hC1); push(2, 371, 1, 8'hD2);
        at(335); p0_req = 1'b0;
        at(362); p1_req = 1'b0;
        at(371); p2_req = 1'b0;
        at(380); check("contention_drained", exp_q.size(), 0);
        // refresh expiry during a port 1 slot with port 0 waiting
        at(751);
        p1_addr = 23'h400055; p1_req = 1'b1;
        push(1, 760, 1, 8'hB5);
        at(753);
        p0_addr = 23'h000066; p0_req = 1'b1;
        push(0, 778, 1, 8'h86);
        at(760); p1_req = 1'b0;
        at(761); check("ref_slot", {mem_refresh, mem_cs, mem_we, busy}, 4'b1001);
        check("ref_addr_hold", mem_addr, 23'h400055);
        at(762); check("ref_hold", mem_refresh, 1);
        at(763); check("ref_low", {mem_refresh, busy}, 2'b01);
        at(769); check("ref_end", {mem_refresh, busy}, 2'b00);
        at(770); check("ref_then_p0", {mem_cs, mem_refresh}, 2'b10);
        check("p0_addr", mem_addr, 23'h000066);
        at(778); p0_req = 1'b0;
        // periodic refresh while idle
        at(1256); check("ref_idle_pre", {mem_refresh, busy}, 2'b00);
        at(1257); check("ref_periodic1", {mem_refresh, busy}, 2'b11);
        at(1266); check("ref_no_repeat", {mem_refresh, busy}, 2'b00);
        at(1757); check("ref_periodic2", {mem_refresh, busy}, 2'b11);
        // reset in the middle of a port 2 write
        at(1800);
        p2_addr = 23'h000077; p2_din = 8'h5A; p2_we = 1'b1; p2_req = 1'b1;
        at(1805); check("mid_pre", {busy, mem_we}, 2'b11);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst", {mem_cs, mem_we, busy, init_done, p2_ack}, 0);
        push(2, 265, 1, 8'h00);
        reset_n = 1'b1;
        bad = 0;
        for (int i = 1; i < 256; i++) begin
            at(i);
            if (mem_cs || busy || init_done) bad = 1;
        end
        check("reinit_quiet", bad, 0);
        at(256); check("reinit_done", init_done, 1);
        at(257); check("rewr_start", {mem_cs, mem_we, mem_din}, {2'b11, 8'h5A});
        at(265); p2_req = 1'b0; p2_we = 1'b0;
        at(270); check("final_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
